// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the parametrised UART transmitter.
//   - PAR_NONE / PAR_EVEN / PAR_ODD : parity mode encodings (2'b11 behaves as none)
//   - TICKS_PER_BIT                 : 16x oversampling ticks per serial bit
//   - txState_e                     : transmitter FSM state encoding
//   - parityEnabled / parityBit     : parity helpers used by the serialiser
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int unsigned TICKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } txState_e;

    function automatic logic parityEnabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // dataXor is the reduction XOR of the payload.
    function automatic logic parityBit(input logic [1:0] mode, input logic dataXor);
        return (mode == PAR_ODD) ? ~dataXor : dataXor;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered status flags.
// Ports:
//   iClk, iRst      clock, synchronous active-high reset
//   iPush/iPushData write strobe and word; ignored when full unless a pop happens alongside
//   iPop            read strobe; ignored when empty
//   oHeadData       word at the head of the queue (valid when !oEmpty)
//   oFull, oEmpty   registered status
//   oLevel          registered occupancy, 0..P_DEPTH
module sync_fifo #(
    parameter int unsigned P_DATA_W = 8,
    parameter int unsigned P_DEPTH  = 16
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iPush,
    input  logic [P_DATA_W-1:0]       iPushData,
    input  logic                      iPop,
    output logic [P_DATA_W-1:0]       oHeadData,
    output logic                      oFull,
    output logic                      oEmpty,
    output logic [$clog2(P_DEPTH):0]  oLevel
);

    localparam int unsigned PTR_W = $clog2(P_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [P_DATA_W-1:0] mem [P_DEPTH];
    logic [PTR_W-1:0]    wrPtrQ;
    logic [PTR_W-1:0]    rdPtrQ;
    logic [LVL_W-1:0]    levelQ;
    logic [LVL_W-1:0]    levelD;
    logic                fullQ;
    logic                emptyQ;
    logic                doPush;
    logic                doPop;

    always_comb begin
        doPop  = iPop && !emptyQ;
        // A pop in the same cycle frees the slot, so a push at full is still taken.
        doPush = iPush && (!fullQ || doPop);
        levelD = levelQ;
        if (doPush && !doPop) begin
            levelD = levelQ + LVL_W'(1);
        end else if (doPop && !doPush) begin
            levelD = levelQ - LVL_W'(1);
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            levelQ <= '0;
            fullQ  <= 1'b0;
            emptyQ <= 1'b1;
        end else begin
            if (doPush) begin
                wrPtrQ <= wrPtrQ + PTR_W'(1);
            end
            if (doPop) begin
                rdPtrQ <= rdPtrQ + PTR_W'(1);
            end
            levelQ <= levelD;
            fullQ  <= (levelD == LVL_W'(P_DEPTH));
            emptyQ <= (levelD == '0);
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge iClk) begin
        if (doPush) begin
            mem[wrPtrQ] <= iPushData;
        end
    end

    assign oHeadData = mem[rdPtrQ];
    assign oFull     = fullQ;
    assign oEmpty    = emptyQ;
    assign oLevel    = levelQ;

endmodule

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: FIFO-buffered UART transmitter with configurable data width,
// parity and stop bits, timed by a shared 16x baud tick.
// Optional feature macro: UART_TX_OVF_FLAG_EN (sticky overflow flag on dropped pushes).
// Ports:
//   iClk, iRst            clock, synchronous active-high reset
//   iTick16x              one-cycle pulse at 16x baud
//   iPushValid/iPushData  FIFO write
//   iPopValid             manual frame start (ignored when P_AUTO_DRAIN=1)
//   iParityMode           00 none, 01 even, 10 odd, 11 none; latched per frame
//   iStopBits2            two stop bits when set; latched per frame
//   iOvfClr               clears oOverflow
//   oTx                   registered serial output, idle high
//   oBusy                 frame in progress
//   oFull/oEmpty/oLevel   FIFO status
//   oPopData              payload of the most recently started frame
//   oOverflow             sticky drop flag (0 when the feature is not built)
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int unsigned P_DATA_W     = 8,
    parameter int unsigned P_DEPTH      = 16,
    parameter int unsigned P_AUTO_DRAIN = 0
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iTick16x,
    input  logic                      iPushValid,
    input  logic [P_DATA_W-1:0]       iPushData,
    input  logic                      iPopValid,
    input  logic [1:0]                iParityMode,
    input  logic                      iStopBits2,
    input  logic                      iOvfClr,
    output logic                      oTx,
    output logic                      oBusy,
    output logic                      oFull,
    output logic                      oEmpty,
    output logic [$clog2(P_DEPTH):0]  oLevel,
    output logic [P_DATA_W-1:0]       oPopData,
    output logic                      oOverflow
);

    localparam int unsigned TICK_W = $clog2(TICKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(P_DATA_W);

    txState_e            stateQ, stateD;
    logic [TICK_W-1:0]   tickCntQ, tickCntD;
    logic [BIT_W-1:0]    bitIdxQ, bitIdxD;
    logic [P_DATA_W-1:0] popDataQ, popDataD;
    logic [1:0]          parModeQ, parModeD;
    logic                stop2Q, stop2D;
    logic                stopSecondQ, stopSecondD;
    logic                txQ, txD;

    logic                popReq;
    logic                bitEnd;
    logic [P_DATA_W-1:0] fifoHead;
    logic                fifoFull;
    logic                fifoEmpty;

    assign popReq = ((P_AUTO_DRAIN != 0) ? 1'b1 : iPopValid)
                    && (stateQ == StIdle) && !fifoEmpty;

    sync_fifo #(
        .P_DATA_W (P_DATA_W),
        .P_DEPTH  (P_DEPTH)
    ) uFifo (
        .iClk      (iClk),
        .iRst      (iRst),
        .iPush     (iPushValid),
        .iPushData (iPushData),
        .iPop      (popReq),
        .oHeadData (fifoHead),
        .oFull     (fifoFull),
        .oEmpty    (fifoEmpty),
        .oLevel    (oLevel)
    );

    assign bitEnd = iTick16x && (tickCntQ == TICK_W'(TICKS_PER_BIT - 1));

    always_comb begin
        stateD      = stateQ;
        tickCntD    = tickCntQ;
        bitIdxD     = bitIdxQ;
        popDataD    = popDataQ;
        parModeD    = parModeQ;
        stop2D      = stop2Q;
        stopSecondD = stopSecondQ;
        txD         = 1'b1;

        // Ticks only count while a frame is running.
        if ((stateQ != StIdle) && iTick16x) begin
            tickCntD = bitEnd ? '0 : tickCntQ + TICK_W'(1);
        end

        case (stateQ)
            StIdle: begin
                if (popReq) begin
                    stateD   = StStart;
                    tickCntD = '0;
                    popDataD = fifoHead;
                    parModeD = iParityMode;
                    stop2D   = iStopBits2;
                end
            end
            StStart: begin
                if (bitEnd) begin
                    stateD  = StData;
                    bitIdxD = '0;
                end
            end
            StData: begin
                if (bitEnd) begin
                    if (bitIdxQ == BIT_W'(P_DATA_W - 1)) begin
                        stateD      = parityEnabled(parModeQ) ? StParity : StStop;
                        stopSecondD = 1'b0;
                    end else begin
                        bitIdxD = bitIdxQ + BIT_W'(1);
                    end
                end
            end
            StParity: begin
                if (bitEnd) begin
                    stateD      = StStop;
                    stopSecondD = 1'b0;
                end
            end
            StStop: begin
                if (bitEnd) begin
                    // Two stop bits are run as two back-to-back 16-tick periods.
                    if (stop2Q && !stopSecondQ) begin
                        stopSecondD = 1'b1;
                    end else begin
                        stateD = StIdle;
                    end
                end
            end
            default: begin
                stateD = StIdle;
            end
        endcase

        // Line level is decoded from the next state so oTx comes straight from a flop.
        case (stateD)
            StStart:  txD = 1'b0;
            StData:   txD = popDataD[bitIdxD];
            StParity: txD = parityBit(parModeD, ^popDataD);
            default:  txD = 1'b1;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            stateQ      <= StIdle;
            tickCntQ    <= '0;
            bitIdxQ     <= '0;
            popDataQ    <= '0;
            parModeQ    <= PAR_NONE;
            stop2Q      <= 1'b0;
            stopSecondQ <= 1'b0;
            txQ         <= 1'b1;
        end else begin
            stateQ      <= stateD;
            tickCntQ    <= tickCntD;
            bitIdxQ     <= bitIdxD;
            popDataQ    <= popDataD;
            parModeQ    <= parModeD;
            stop2Q      <= stop2D;
            stopSecondQ <= stopSecondD;
            txQ         <= txD;
        end
    end

    assign oTx      = txQ;
    assign oBusy    = (stateQ != StIdle);
    assign oFull    = fifoFull;
    assign oEmpty   = fifoEmpty;
    assign oPopData = popDataQ;

`ifdef UART_TX_OVF_FLAG_EN
    logic pushDropped;
    logic ovfQ;

    // Mirrors the FIFO accept rule: a push at full survives only alongside a pop.
    assign pushDropped = iPushValid && fifoFull && !popReq;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            ovfQ <= 1'b0;
        end else if (pushDropped) begin
            ovfQ <= 1'b1;
        end else if (iOvfClr) begin
            ovfQ <= 1'b0;
        end
    end

    assign oOverflow = ovfQ;
`else
    logic unusedOvfClr;
    assign unusedOvfClr = iOvfClr;
    assign oOverflow    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param: a manual-pop instance carries the FIFO,
// framing, parity, stop-bit and reset cases; an auto-drain instance checks
// back-to-back frames.
module tb_uart_tx_fifo_param;

`ifdef UART_TX_OVF_FLAG_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       pushValid = 1'b0;
    logic [7:0] pushData = 8'h00;
    logic       popValid = 1'b0;
    logic [1:0] parMode = 2'b00;
    logic       stop2 = 1'b0;
    logic       ovfClr = 1'b0;
    logic       push2Valid = 1'b0;
    logic [7:0] push2Data = 8'h00;

    logic       tx, busy, full, empty, ovf;
    logic [4:0] level;
    logic [7:0] popData;
    logic       tx2, busy2, empty2;
    logic       unusedFull2, unusedOvf2;
    logic [4:0] level2;
    logic [7:0] popData2;

    int nAsserts = 0;
    int nFail = 0;
    int tickDiv = 0;

    uart_tx_fifo_param #(.P_DATA_W(8), .P_DEPTH(16), .P_AUTO_DRAIN(0)) dut (
        .iClk(clk), .iRst(rst), .iTick16x(tick), .iPushValid(pushValid),
        .iPushData(pushData), .iPopValid(popValid), .iParityMode(parMode),
        .iStopBits2(stop2), .iOvfClr(ovfClr), .oTx(tx), .oBusy(busy), .oFull(full),
        .oEmpty(empty), .oLevel(level), .oPopData(popData), .oOverflow(ovf)
    );

    uart_tx_fifo_param #(.P_DATA_W(8), .P_DEPTH(16), .P_AUTO_DRAIN(1)) dut2 (
        .iClk(clk), .iRst(rst), .iTick16x(tick), .iPushValid(push2Valid),
        .iPushData(push2Data), .iPopValid(popValid), .iParityMode(parMode),
        .iStopBits2(stop2), .iOvfClr(ovfClr), .oTx(tx2), .oBusy(busy2),
        .oFull(unusedFull2), .oEmpty(empty2), .oLevel(level2), .oPopData(popData2),
        .oOverflow(unusedOvf2)
    );

    always #5 clk = ~clk;

    // 16x tick every 4 clocks, changed 1 ns after the edge.
    always @(posedge clk) begin
        #1;
        tickDiv = (tickDiv + 1) % 4;
        tick = (tickDiv == 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic waitTicks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (tick) k++;
        end
        #1;
    endtask

    // Called 1 ns after the edge that entered START. bits[0] is the start bit.
    task automatic checkFrame(input logic [15:0] bits, input int n, input logic holdPop);
        for (int i = 0; i < n; i++) begin
            if (i == 0) popValid = holdPop;
            waitTicks(8);
            popValid = 1'b0;
            chk($sformatf("txBit%0d", i), 32'(tx), 32'(bits[i]));
            chk($sformatf("busyBit%0d", i), 32'(busy), 1);
            if (i == n - 1) begin
                waitTicks(7);
                chk("busyLastTick", 32'(busy), 1);
                waitTicks(1);
                chk("busyEnd", 32'(busy), 0);
                chk("txIdleAfter", 32'(tx), 1);
            end else begin
                waitTicks(8);
            end
        end
    endtask

    initial begin
        logic [7:0] words [3];
        int cnt;
        words[0] = 8'h11;
        words[1] = 8'h22;
        words[2] = 8'h33;

        // Reset state
        repeat (3) cyc();
        chk("rstTx", 32'(tx), 1);
        chk("rstBusy", 32'(busy), 0);
        chk("rstFull", 32'(full), 0);
        chk("rstEmpty", 32'(empty), 1);
        chk("rstLevel", 32'(level), 0);
        chk("rstPopData", 32'(popData), 0);
        chk("rstOvf", 32'(ovf), 0);
        rst = 1'b0;

        // Fill to full, then a dropped push
        for (int i = 0; i < 16; i++) begin
            pushValid = 1'b1;
            pushData = 8'(i);
            cyc();
        end
        pushValid = 1'b0;
        chk("fillFull", 32'(full), 1);
        chk("fillLevel", 32'(level), 16);
        chk("fillEmpty", 32'(empty), 0);
        pushValid = 1'b1;
        pushData = 8'hAA;
        cyc();
        pushValid = 1'b0;
        chk("dropLevel", 32'(level), 16);
        chk("dropFull", 32'(full), 1);
        chk("dropOvf", 32'(ovf), 32'(EXP_OVF));
        ovfClr = 1'b1;
        cyc();
        ovfClr = 1'b0;
        chk("ovfCleared", 32'(ovf), 0);

        // Push+pop at full: level holds, head 0x00 goes out first
        pushValid = 1'b1;
        pushData = 8'h55;
        popValid = 1'b1;
        cyc();
        pushValid = 1'b0;
        popValid = 1'b0;
        chk("ppFullLevel", 32'(level), 16);
        chk("ppFullFull", 32'(full), 1);
        chk("ppFullPopData", 32'(popData), 8'h00);
        chk("ppFullBusy", 32'(busy), 1);
        chk("ppFullStartTx", 32'(tx), 0);
        checkFrame(16'h0200, 10, 1'b0);

        // Next word is 0x01; reset during its DATA bit1 (line low)
        popValid = 1'b1;
        cyc();
        popValid = 1'b0;
        chk("orderPopData", 32'(popData), 8'h01);
        chk("orderLevel", 32'(level), 15);
        waitTicks(40);
        chk("midDataTx", 32'(tx), 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("abortTx", 32'(tx), 1);
        chk("abortBusy", 32'(busy), 0);
        chk("abortEmpty", 32'(empty), 1);
        chk("abortLevel", 32'(level), 0);
        chk("abortFull", 32'(full), 0);

        // Push+pop on empty: push taken, no frame
        pushValid = 1'b1;
        pushData = 8'h55;
        popValid = 1'b1;
        cyc();
        pushValid = 1'b0;
        popValid = 1'b0;
        chk("ppEmptyLevel", 32'(level), 1);
        chk("ppEmptyEmpty", 32'(empty), 0);
        chk("ppEmptyBusy", 32'(busy), 0);
        repeat (3) cyc();
        chk("ppEmptyStillIdle", 32'(busy), 0);
        chk("ppEmptyIdleTx", 32'(tx), 1);

        // 0x55, no parity, one stop bit
        popValid = 1'b1;
        cyc();
        popValid = 1'b0;
        chk("p55PopData", 32'(popData), 8'h55);
        chk("p55Busy", 32'(busy), 1);
        chk("p55Empty", 32'(empty), 1);
        chk("p55Level", 32'(level), 0);
        checkFrame(16'h02AA, 10, 1'b0);

        // Two 0x07 words; even parity then odd parity with two stop bits
        for (int i = 0; i < 2; i++) begin
            pushValid = 1'b1;
            pushData = 8'h07;
            cyc();
        end
        pushValid = 1'b0;
        parMode = 2'b01;
        stop2 = 1'b0;
        popValid = 1'b1;
        cyc();
        popValid = 1'b0;
        // Settings change mid-frame must not affect the running frame
        parMode = 2'b00;
        stop2 = 1'b1;
        checkFrame(16'h060E, 11, 1'b1);
        chk("popWhileBusyLevel", 32'(level), 1);
        cyc();
        chk("popWhileBusyIdle", 32'(busy), 0);
        parMode = 2'b10;
        stop2 = 1'b1;
        popValid = 1'b1;
        cyc();
        popValid = 1'b0;
        parMode = 2'b00;
        stop2 = 1'b0;
        chk("oddPopData", 32'(popData), 8'h07);
        checkFrame(16'h0C0E, 12, 1'b0);
        chk("oddEmpty", 32'(empty), 1);

        // Auto-drain: three frames with exactly one idle cycle between
        for (int i = 0; i < 3; i++) begin
            push2Valid = 1'b1;
            push2Data = words[i];
            cyc();
        end
        push2Valid = 1'b0;
        chk("adFirstBusy", 32'(busy2), 1);
        chk("adFirstPopData", 32'(popData2), 8'h11);
        chk("adFirstTx", 32'(tx2), 0);
        chk("adLevel", 32'(level2), 2);
        for (int k = 1; k < 3; k++) begin
            cnt = 0;
            while (busy2 && cnt < 3000) begin
                cyc();
                cnt++;
            end
            chk($sformatf("adIdle%0d", k), 32'(busy2), 0);
            chk($sformatf("adIdleTx%0d", k), 32'(tx2), 1);
            cyc();
            chk($sformatf("adRestart%0d", k), 32'(busy2), 1);
            chk($sformatf("adPopData%0d", k), 32'(popData2), 32'(words[k]));
        end
        chk("adEmpty", 32'(empty2), 1);
        chk("adLevelEnd", 32'(level2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_param.md
Name: uart_tx_fifo_param

Overview:
Parametrised successor to the fixed 8-bit UART TX + FIFO block.
- Buffers words in a synchronous FIFO of configurable depth.
- Serialises each word as an 8N1/8E1/8O1/…-style frame, with configurable data width, parity and stop bits.
- Pops under either a manual pop pulse or automatic drain.
- Sits between the CPU/bus push side and the UART pin; timing comes from the shared 16x baud tick generator.

Parameters:
- P_DATA_W, 8, data bits per frame, legal 5..9.
- P_DEPTH, 16, FIFO entries, power of two, ≥2.
- P_AUTO_DRAIN, 0. 1: TX pops whenever idle and FIFO not empty. 0: pop only on iPopValid.

Ports:
- iClk  in  1  system clock
- iRst  in  1  synchronous, active-high reset
- iTick16x  in  1  one-cycle pulse at 16x baud
- iPushValid  in  1  push strobe
- iPushData  in  P_DATA_W  push word
- iPopValid  in  1  manual pop/start strobe; ignored when P_AUTO_DRAIN=1
- iParityMode  in  2  00 none, 01 even, 10 odd, 11 treated as none
- iStopBits2  in  1  0: one stop bit, 1: two stop bits
- iOvfClr  in  1  clears oOverflow
- oTx  out  1  serial line, idle high
- oBusy  out  1  frame in progress
- oFull  out  1  FIFO full
- oEmpty  out  1  FIFO empty
- oLevel  out  $clog2(P_DEPTH)+1  FIFO occupancy
- oPopData  out  P_DATA_W  word most recently popped (frame payload)
- oOverflow  out  1  sticky overflow flag (see Optional Feature)

Behaviour:
Reset (iRst high at a clock edge):
- oTx=1, oBusy=0, oFull=0, oEmpty=1, oLevel=0, oPopData=0, oOverflow=0.
- FIFO pointers cleared; FSM returns to IDLE.
- Reset mid-frame aborts the frame; oTx is high the cycle after the reset edge.

FIFO:
- Write when iPushValid && !oFull. Pointers wrap modulo P_DEPTH.
- oFull/oEmpty/oLevel are registered and reflect the accepted op in the next cycle.
- Push while full is dropped.
- Simultaneous push+pop when full: both occur, level unchanged.
- Simultaneous push+pop when empty: push accepted, pop ignored (no fall-through).

Pop request:
- Request = (P_AUTO_DRAIN ? 1 : iPopValid) && state==IDLE && !oEmpty.
- iPopValid while busy or empty is ignored, not queued.
- On an accepted pop in cycle N:
  - oPopData loads the head word at N+1.
  - iParityMode/iStopBits2 are latched for the whole frame.
  - oBusy=1 and state=START at N+1.

FSM:
- States: IDLE, START, DATA, PARITY, STOP.
- Tick counter 0..15 advances only on iTick16x; a bit ends on the tick where the count is 15.
- START: oTx=0 for 16 ticks -> DATA.
- DATA: LSB first, P_DATA_W bits, 16 ticks each. Then PARITY if mode is 01/10, else STOP.
- PARITY: bit is ^data for even, ~^data for odd -> STOP.
- STOP: oTx=1 for 16 ticks, or 32 ticks if the latched stop-bits setting is 2 -> IDLE.
- oBusy=0 in the cycle IDLE is entered.
- With P_AUTO_DRAIN=1 and FIFO non-empty, the next pop occurs in that same IDLE cycle: one idle cycle between frames, no extra stop time.

Other:
- oTx is driven from a register; no combinational path from inputs to oTx.
- iTick16x pulses arriving in IDLE are ignored. The counter resets to 0 on entering START.

Optional Feature:
- Macro: UART_TX_OVF_FLAG_EN.
- Defined: oOverflow sets the cycle after any push dropped due to full. It stays set until iOvfClr. If iOvfClr and a new drop occur in the same cycle, set wins.
- Undefined: oOverflow is tied 0, iOvfClr is unused, and no flag register is built.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - FSM state encoding typedef;
  - TICKS_PER_BIT=16.
- Sub-module sync_fifo (P_DATA_W, P_DEPTH) provides push/pop/full/empty/level.
- The FSM and shifter remain in the top.

Test Plan (P_DATA_W=8, P_DEPTH=16, tick divider 651 at 100 MHz):
1. Push 0..15 -> oFull=1 after 16th push, oLevel=16. Push 0xAA while full -> dropped; oOverflow=1 with macro; oLevel stays 16.
2. Manual pop of 0x55, parity none, 1 stop -> oTx frame 0,1,0,1,0,1,0,1,0,1, each bit 16 ticks; oBusy high for 160 ticks; oPopData=0x55.
3. Even parity on 0x07 -> parity bit 1. Odd parity on 0x07 -> parity bit 0. iStopBits2=1 -> stop high for 32 ticks; oBusy for 192 ticks.
4. P_AUTO_DRAIN=1, push 3 words -> three back-to-back frames in push order, with exactly one IDLE cycle between them. oEmpty=1 after the third pop.
5. Assert iRst mid-DATA -> oTx=1, oBusy=0, oEmpty=1, oLevel=0 next cycle. A subsequent push+pop sends a clean frame.
6. Push and pop in the same cycle when level=16 -> level stays 16 and the word order is preserved. The same on empty -> level becomes 1 and no frame starts.
